// File: rtl/alu_share_arbiter_if.sv
// Bundle between requesters, the shared ALU and the response consumer.
// slave: arbiter side. master: clients, ALU and consumer side.
// stat_grants exists only when ALU_ARB_STATS_EN is defined.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_op;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [3:0]            alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic [4:0]            alu_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic [4:0]            rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_grants;
`endif

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_result, rsp_flags
`ifdef ALU_ARB_STATS_EN
    , output stat_grants
`endif
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags
`ifdef ALU_ARB_STATS_EN
    , input stat_grants
`endif
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one registered ALU among NREQ requesters, with
// ID-tagged results returned through a credit-protected response FIFO.
// Ports: clk, rst (async, active-high), bus (alu_share_arbiter_if.slave):
//   req_* request handshakes, alu_* ALU drive/return, rsp_* responses.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters
// on bus.stat_grants.
module alu_share_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NREQ      = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  localparam logic [CW-1:0] CMAX = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [PW:0]   PONE = (PW+1)'(1);

  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];
  logic [3:0]       op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = bus.req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = bus.req_b[i*WIDTH +: WIDTH];
    assign op_arr[i] = bus.req_op[i*4 +: 4];
  end

  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [CW-1:0]    credits_q;
  logic [CW-1:0]    credits_d;

  logic             iss_v_q;
  logic [IDW-1:0]   iss_id_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_op_q;
  logic             alu_v_q;
  logic [IDW-1:0]   alu_id_q;

  logic [IDW-1:0]   fid_q  [RSP_DEPTH];
  logic [WIDTH-1:0] fres_q [RSP_DEPTH];
  logic [4:0]       ffl_q  [RSP_DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               idx;
  logic             credit_ok;
  logic             grant;
  logic             rsp_v;
  logic             pop;

  // Scan from rr_ptr upward, wrapping at NREQ; first valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A grant needs a reserved slot covering issue, ALU and FIFO stages.
  assign credit_ok = (credits_q < CMAX);
  assign grant     = found & credit_ok & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
    end
  end

  assign rsp_v = (wr_ptr_q != rd_ptr_q);
  assign pop   = rsp_v & bus.rsp_ready;

  always_comb begin
    credits_d = credits_q;
    unique case ({grant, pop})
      2'b10:   credits_d = credits_q + CONE;
      2'b01:   credits_d = credits_q - CONE;
      default: credits_d = credits_q;
    endcase
  end

  // Issue stage and the valid/ID shadow aligned with the ALU's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      credits_q <= '0;
      iss_v_q   <= 1'b0;
      iss_id_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_v_q   <= 1'b0;
      alu_id_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      iss_v_q   <= grant;
      alu_v_q   <= iss_v_q;
      alu_id_q  <= iss_id_q;
      if (grant) begin
        iss_id_q <= win;
        alu_a_q  <= a_arr[win];
        alu_b_q  <= b_arr[win];
        alu_op_q <= op_arr[win];
      end
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;

  // Response FIFO; credits guarantee a free slot on every push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fid_q[i]  <= '0;
        fres_q[i] <= '0;
        ffl_q[i]  <= '0;
      end
    end else begin
      if (alu_v_q) begin
        fid_q[wr_ptr_q[PW-1:0]]  <= alu_id_q;
        fres_q[wr_ptr_q[PW-1:0]] <= bus.alu_result;
        ffl_q[wr_ptr_q[PW-1:0]]  <= bus.alu_flags;
        wr_ptr_q <= wr_ptr_q + PONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PONE;
    end
  end

  assign bus.rsp_valid  = rsp_v;
  assign bus.rsp_id     = fid_q[rd_ptr_q[PW-1:0]];
  assign bus.rsp_result = fres_q[rd_ptr_q[PW-1:0]];
  assign bus.rsp_flags  = ffl_q[rd_ptr_q[PW-1:0]];

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (grant && stat_q[win] != 16'hFFFF) begin
      stat_q[win] <= stat_q[win] + 16'd1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    assign bus.stat_grants[i*16 +: 16] = stat_q[i];
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered ALU.
// Opcodes used by the ALU model: 0 ADD, 1 SUB, 2 AND, 3 CMP, others invalid.
module tb_alu_share_arbiter;
  localparam int WIDTH     = 16;
  localparam int NREQ      = 4;
  localparam int RSP_DEPTH = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

  alu_share_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // flags: {is_less, is_equal, invalid_op, underflow, overflow}
  function automatic logic [20:0] alu_f(
    input logic [15:0] a, input logic [15:0] b, input logic [3:0] op
  );
    logic [16:0] s;
    logic [4:0]  f;
    logic [15:0] r;
    f = '0;
    r = '0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; f[0] = s[16]; end
      OP_SUB: begin r = a - b; f[1] = (a < b); end
      OP_AND: r = a & b;
      OP_CMP: begin f[4] = (a < b); f[3] = (a == b); end
      default: f[2] = 1'b1;
    endcase
    return {f, r};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {bus.alu_flags, bus.alu_result} <= '0;
    else {bus.alu_flags, bus.alu_result} <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] op);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_op[i*4 +: 4]        = op;
  endtask

  // Requester i: a = 16*i+1, b = i, ADD -> result 17*i+1.
  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16*i+1), 16'(i), OP_ADD);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    load_ops();
    tick();
    tick();
    bus.req_valid = '1;
    #1;
    checks++; if (bus.req_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    checks++; if (bus.alu_a !== 16'h0) begin fails++; $display("FAIL reset_alu_a got %h want 0000", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0) begin fails++; $display("FAIL reset_alu_b got %h want 0000", bus.alu_b); end
    checks++; if (bus.alu_op !== 4'h0) begin fails++; $display("FAIL reset_alu_op got %h want 0", bus.alu_op); end
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 16'h0) begin fails++; $display("FAIL reset_rsp_result got %h want 0000", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 5'h0) begin fails++; $display("FAIL reset_rsp_flags got %b want 00000", bus.rsp_flags); end
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(2, 16'h0003, 16'h0004, OP_ADD);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {16'h0003, 16'h0004, OP_ADD}) begin
      fails++; $display("FAIL single_issue got a=%h b=%h op=%h want 0003 0004 0", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early1 rsp_valid got %b want 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early2 rsp_valid got %b want 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd2) begin fails++; $display("FAIL single_id got %0d want 2", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 16'h0007) begin fails++; $display("FAIL single_result got %h want 0007", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 5'b0) begin fails++; $display("FAIL single_flags got %b want 00000", bus.rsp_flags); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_pop rsp_valid got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_fairness();
    int nrsp;
    logic [3:0] exp_rdy;
    nrsp = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_ops();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 12) bus.req_valid = '0;
      #1;
      exp_rdy = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL fair_grant c=%0d got %b want %b", c, bus.req_ready, exp_rdy); end
      if (bus.rsp_valid === 1'b1) begin
        checks++; if (bus.rsp_id !== 2'(nrsp % 4)) begin fails++; $display("FAIL fair_order n=%0d got id %0d want %0d", nrsp, bus.rsp_id, nrsp % 4); end
        checks++; if (bus.rsp_result !== 16'(17*(nrsp % 4)+1)) begin fails++; $display("FAIL fair_result n=%0d got %h want %h", nrsp, bus.rsp_result, 16'(17*(nrsp % 4)+1)); end
        nrsp++;
      end
      tick();
    end
    checks++; if (nrsp != 12) begin fails++; $display("FAIL fair_count got %0d want 12", nrsp); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id [4];
    exp_id[0] = 2'd2; exp_id[1] = 2'd3; exp_id[2] = 2'd0; exp_id[3] = 2'd0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_rdy = (c < 4) ? (4'b0001 << c) : 4'b0000;
      checks++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL bp_grant c=%0d got %b want %b", c, bus.req_ready, exp_rdy); end
      tick();
    end
    checks++; if (dut.credits_q !== 3'd4) begin fails++; $display("FAIL bp_credits got %0d want 4", dut.credits_q); end
    checks++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_full_valid got %b want 1", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_pop_cycle_ready got %b want 0000", bus.req_ready); end
    checks++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL bp_drain0 got id %0d want 0", bus.rsp_id); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL bp_resume got %b want 0001", bus.req_ready); end
    checks++; if (bus.rsp_id !== 2'd1) begin fails++; $display("FAIL bp_drain1 got id %0d want 1", bus.rsp_id); end
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id[k]) begin
        fails++; $display("FAIL bp_drain k=%0d got v=%b id=%0d want v=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, exp_id[k]);
      end
      tick();
    end
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_flags();
    set_req(1, 16'h0001, 16'h0002, OP_SUB);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL sub_ready got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd1}) begin fails++; $display("FAIL sub_id got v=%b id=%0d want v=1 id=1", bus.rsp_valid, bus.rsp_id); end
    checks++; if (bus.rsp_result !== 16'hFFFF) begin fails++; $display("FAIL sub_result got %h want ffff", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 5'b00010) begin fails++; $display("FAIL sub_flags got %b want 00010", bus.rsp_flags); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    set_req(3, 16'h0005, 16'h0006, OP_BAD);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin fails++; $display("FAIL bad_ready got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd3}) begin fails++; $display("FAIL bad_id got v=%b id=%0d want v=1 id=3", bus.rsp_valid, bus.rsp_id); end
    checks++; if (bus.rsp_result !== 16'h0000) begin fails++; $display("FAIL bad_result got %h want 0000", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 5'b00100) begin fails++; $display("FAIL bad_flags got %b want 00100", bus.rsp_flags); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    load_ops();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_rsp c=%0d got %b want 0", c, bus.rsp_valid); end
      tick();
    end
    checks++; if (dut.credits_q !== 3'd0) begin fails++; $display("FAIL mid_credits got %0d want 0", dut.credits_q); end
    bus.req_valid = '1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.rsp_ready = 1'b0;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    logic [15:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    for (int i = 0; i < NREQ; i++) begin
      exp = (i == 1) ? 16'd5 : 16'd0;
      checks++; if (bus.stat_grants[i*16 +: 16] !== exp) begin
        fails++; $display("FAIL stats_%0d got %0d want %0d", i, bus.stat_grants[i*16 +: 16], exp);
      end
    end
    bus.rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_flags();
    test_reset_midflight();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
